// File: rtl/wb_retire_queue.sv
// In-order writeback retire queue: buffers MEM results, retires them to the RF and
// trace port when the sink is ready, squashes younger work on exceptions, forwards queued writes to ID.
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int WE_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic                                  wb_allowin,
  input  logic                                  mem_to_wb_valid,
  input  logic [1+WE_W+ADDR_W+DATA_W+PC_W-1:0]  mem_to_wb_wire,
  input  logic                                  wb_flush,
  input  logic                                  trace_ready,
  output logic [PC_W-1:0]                       debug_wb_pc,
  output logic [WE_W-1:0]                       debug_wb_rf_we,
  output logic [ADDR_W-1:0]                     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                     debug_wb_rf_wdata,
  output logic [ADDR_W+DATA_W:0]                wb_rf_zip,
  input  logic [2*ADDR_W-1:0]                   fwd_raddr,
  output logic [1:0]                            fwd_hit,
  output logic [2*DATA_W-1:0]                   fwd_data,
  output logic                                  wb_ex,
  output logic [PC_W-1:0]                       wb_ex_pc,
  output logic [$clog2(DEPTH):0]                wb_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int ENT_W = 1 + WE_W + ADDR_W + DATA_W + PC_W;

  logic              ent_ex    [DEPTH];
  logic [WE_W-1:0]   ent_we    [DEPTH];
  logic [ADDR_W-1:0] ent_waddr [DEPTH];
  logic [DATA_W-1:0] ent_wdata [DEPTH];
  logic [PC_W-1:0]   ent_pc    [DEPTH];

  logic [CNT_W-1:0] rd_ptr, wr_ptr, count;
  logic [IDX_W-1:0] head, tail;
  logic empty, full, push, retire, ex_retire;
  logic [DATA_W:0] fwd0, fwd1;

  assign head  = rd_ptr[IDX_W-1:0];
  assign tail  = wr_ptr[IDX_W-1:0];
  assign count = wr_ptr - rd_ptr;
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (head == tail) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

  assign wb_allowin = ~full;
  assign wb_count   = count;
  assign retire     = ~empty & trace_ready;
  assign ex_retire  = retire & ent_ex[head];
  assign push       = mem_to_wb_valid & ~full & ~wb_flush & ~ex_retire;

  assign debug_wb_pc       = ent_pc[head];
  assign debug_wb_rf_wnum  = ent_waddr[head];
  assign debug_wb_rf_wdata = ent_wdata[head];
  assign debug_wb_rf_we    = (retire && !ent_ex[head]) ? ent_we[head] : '0;
  assign wb_rf_zip         = {|debug_wb_rf_we, ent_waddr[head], ent_wdata[head]};

  // Oldest-to-youngest walk so the last (youngest) qualifying entry wins.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0]  res;
    logic [CNT_W-1:0] pos;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = rd_ptr + CNT_W'(i);
      if ((CNT_W'(i) < count) && (ent_we[pos[IDX_W-1:0]] != '0) &&
          !ent_ex[pos[IDX_W-1:0]] && (addr != '0) &&
          (ent_waddr[pos[IDX_W-1:0]] == addr))
        res = {1'b1, ent_wdata[pos[IDX_W-1:0]]};
    end
    return res;
  endfunction

  always_comb begin
    fwd0     = fwd_lookup(fwd_raddr[ADDR_W-1:0]);
    fwd1     = fwd_lookup(fwd_raddr[2*ADDR_W-1:ADDR_W]);
    fwd_hit  = {fwd1[DATA_W], fwd0[DATA_W]};
    fwd_data = {fwd1[DATA_W-1:0], fwd0[DATA_W-1:0]};
  end

  // Pointer and exception-pulse state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      wb_ex    <= 1'b0;
      wb_ex_pc <= '0;
    end else begin
      wb_ex <= ex_retire;
      if (ex_retire)
        wb_ex_pc <= ent_pc[head];
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      // Flush and exception both squash everything behind the head; push is already blocked.
      if (ex_retire || wb_flush)
        rd_ptr <= wr_ptr;
      else if (retire)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage, cleared on reset so the idle debug fields are never X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_ex[i]    <= 1'b0;
        ent_we[i]    <= '0;
        ent_waddr[i] <= '0;
        ent_wdata[i] <= '0;
        ent_pc[i]    <= '0;
      end
    end else if (push) begin
      ent_ex[tail]    <= mem_to_wb_wire[ENT_W-1];
      ent_we[tail]    <= mem_to_wb_wire[PC_W+DATA_W+ADDR_W +: WE_W];
      ent_waddr[tail] <= mem_to_wb_wire[PC_W+DATA_W +: ADDR_W];
      ent_wdata[tail] <= mem_to_wb_wire[PC_W +: DATA_W];
      ent_pc[tail]    <= mem_to_wb_wire[PC_W-1:0];
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue: stimulus queues expected retires/exceptions,
// a negedge monitor pops and compares whatever the DUT retires.
module tb_wb_retire_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 32;
  localparam int WE_W   = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int ENT_W  = 1 + WE_W + ADDR_W + DATA_W + PC_W;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     wb_allowin;
  logic                     mem_to_wb_valid;
  logic [ENT_W-1:0]         mem_to_wb_wire;
  logic                     wb_flush;
  logic                     trace_ready;
  logic [PC_W-1:0]          debug_wb_pc;
  logic [WE_W-1:0]          debug_wb_rf_we;
  logic [ADDR_W-1:0]        debug_wb_rf_wnum;
  logic [DATA_W-1:0]        debug_wb_rf_wdata;
  logic [ADDR_W+DATA_W:0]   wb_rf_zip;
  logic [2*ADDR_W-1:0]      fwd_raddr;
  logic [1:0]               fwd_hit;
  logic [2*DATA_W-1:0]      fwd_data;
  logic                     wb_ex;
  logic [PC_W-1:0]          wb_ex_pc;
  logic [CNT_W-1:0]         wb_count;

  wb_retire_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .WE_W(WE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_wire(mem_to_wb_wire),
    .wb_flush(wb_flush), .trace_ready(trace_ready),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .wb_rf_zip(wb_rf_zip), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .wb_ex(wb_ex), .wb_ex_pc(wb_ex_pc), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [WE_W-1:0]   we;
  } exp_t;

  exp_t            exp_q[$];
  logic [PC_W-1:0] exq[$];

  int s_checks = 0, s_errors = 0;
  int m_checks = 0, m_errors = 0;

  // Monitor: every retire with an RF write and every exception pulse is matched to the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_rf_zip[ADDR_W+DATA_W]) begin
        m_checks++;
        if (exp_q.size() == 0) begin
          m_errors++;
          $display("FAIL unexpected_retire pc=%h waddr=%0d wdata=%h required=none", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (debug_wb_pc !== e.pc || debug_wb_rf_wnum !== e.a || debug_wb_rf_wdata !== e.d ||
              debug_wb_rf_we !== e.we || wb_rf_zip[ADDR_W+DATA_W-1:0] !== {e.a, e.d}) begin
            m_errors++;
            $display("FAIL retire pc=%h a=%0d d=%h we=%h required pc=%h a=%0d d=%h we=%h",
                     debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_rf_we, e.pc, e.a, e.d, e.we);
          end
        end
      end
      if (wb_ex) begin
        m_checks++;
        if (exq.size() == 0) begin
          m_errors++;
          $display("FAIL unexpected_wb_ex pc=%h required=none", wb_ex_pc);
        end else begin
          logic [PC_W-1:0] p;
          p = exq.pop_front();
          if (wb_ex_pc !== p) begin
            m_errors++;
            $display("FAIL wb_ex_pc actual=%h required=%h", wb_ex_pc, p);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    s_checks++;
    if (act !== req) begin
      s_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [ENT_W-1:0] mk(input logic ex, input logic [WE_W-1:0] we,
      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [PC_W-1:0] pc);
    return {ex, we, a, d, pc};
  endfunction

  task automatic push_ent(input logic ex, input logic [WE_W-1:0] we, input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] d, input logic [PC_W-1:0] pc, input bit expect_retire);
    exp_t e;
    mem_to_wb_valid = 1'b1;
    mem_to_wb_wire  = mk(ex, we, a, d, pc);
    if (expect_retire) begin
      e.pc = pc; e.a = a; e.d = d; e.we = we;
      exp_q.push_back(e);
    end
    tick();
    mem_to_wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_to_wb_valid = 1'b0; mem_to_wb_wire = '0;
    wb_flush = 1'b0; trace_ready = 1'b0; fwd_raddr = '0;
    tick(); tick();
    reset = 1'b0; trace_ready = 1'b1;
    tick();

    // Idle after reset
    chk("rst_allowin", 64'(wb_allowin), 64'd1);
    chk("rst_count", 64'(wb_count), 64'd0);
    chk("rst_wb_ex", 64'(wb_ex), 64'd0);
    chk("rst_ex_pc", 64'(wb_ex_pc), 64'd0);
    chk("rst_zip_en", 64'(wb_rf_zip[ADDR_W+DATA_W]), 64'd0);
    chk("rst_dbg_we", 64'(debug_wb_rf_we), 64'd0);
    chk("rst_fwd", {62'd0, fwd_hit} ^ fwd_data, 64'd0);

    // Fill to full, then drain in order
    trace_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_ent(1'b0, 4'hF, 5'(i), 32'(i * 'h11), 32'h1c00_0100 + 32'(i * 4), 1'b1);
      if (i == 3) chk("fill3_allowin", 64'(wb_allowin), 64'd1);
    end
    chk("full_count", 64'(wb_count), 64'd4);
    chk("full_allowin", 64'(wb_allowin), 64'd0);
    trace_ready = 1'b1;
    repeat (4) tick();
    chk("drain_count", 64'(wb_count), 64'd0);
    chk("drain_allowin", 64'(wb_allowin), 64'd1);

    // Forwarding: youngest write wins, r0 never forwards
    trace_ready = 1'b0;
    push_ent(1'b0, 4'hF, 5'd5, 32'hA, 32'h1c00_0200, 1'b1);
    push_ent(1'b0, 4'hF, 5'd5, 32'hB, 32'h1c00_0204, 1'b1);
    push_ent(1'b0, 4'hF, 5'd0, 32'h77, 32'h1c00_0208, 1'b1);
    fwd_raddr = {5'd0, 5'd5};
    #1;
    chk("fwd_hit", 64'(fwd_hit), 64'b01);
    chk("fwd_data0", 64'(fwd_data[DATA_W-1:0]), 64'hB);
    chk("fwd_data1_r0", 64'(fwd_data[2*DATA_W-1:DATA_W]), 64'd0);
    trace_ready = 1'b1;
    tick();
    chk("fwd_after1", {31'd0, fwd_hit[0], fwd_data[DATA_W-1:0]}, {32'd1, 32'hB});
    tick();
    chk("fwd_after2", 64'(fwd_hit), 64'd0);
    tick();
    chk("fwd_drain_count", 64'(wb_count), 64'd0);

    // Exception squashes younger work, including a same-cycle push
    trace_ready = 1'b0;
    push_ent(1'b0, 4'hF, 5'd6, 32'h66, 32'h1c00_0000, 1'b1);
    push_ent(1'b1, 4'hF, 5'd7, 32'h71, 32'h1c00_0004, 1'b0);
    push_ent(1'b0, 4'hF, 5'd8, 32'h88, 32'h1c00_0008, 1'b0);
    exq.push_back(32'h1c00_0004);
    fwd_raddr = {5'd8, 5'd7};
    #1;
    chk("fwd_ex_skip", 64'(fwd_hit), 64'b10);
    chk("fwd_ex_data1", 64'(fwd_data[2*DATA_W-1:DATA_W]), 64'h88);
    trace_ready = 1'b1;
    tick();
    push_ent(1'b0, 4'hF, 5'd9, 32'h99, 32'h1c00_000c, 1'b0);
    chk("ex_pulse", 64'(wb_ex), 64'd1);
    chk("ex_pc", 64'(wb_ex_pc), 64'h1c00_0004);
    chk("ex_count", 64'(wb_count), 64'd0);
    tick();
    chk("ex_pulse_end", 64'(wb_ex), 64'd0);
    chk("ex_pc_hold", 64'(wb_ex_pc), 64'h1c00_0004);

    // Full with retire: no pass-through; then flush alongside a retire
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_ent(1'b0, 4'h3, 5'(10 + i), 32'h1000 + 32'(i), 32'h1c00_0300 + 32'(i * 4), i < 2);
    mem_to_wb_valid = 1'b1;
    mem_to_wb_wire  = mk(1'b0, 4'hF, 5'd20, 32'hDEAD, 32'h1c00_0400);
    trace_ready = 1'b1;
    #1;
    chk("full_retire_allowin", 64'(wb_allowin), 64'd0);
    tick();
    mem_to_wb_valid = 1'b0;
    chk("full_retire_count", 64'(wb_count), 64'd3);
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    chk("flush_count", 64'(wb_count), 64'd0);
    chk("flush_allowin", 64'(wb_allowin), 64'd1);
    chk("flush_fwd", 64'(fwd_hit), 64'd0);

    // Reset with entries queued
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_ent(1'b0, 4'hF, 5'(21 + i), 32'h2000 + 32'(i), 32'h1c00_0500 + 32'(i * 4), 1'b0);
    chk("pre_reset_count", 64'(wb_count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset_count", 64'(wb_count), 64'd0);
    chk("post_reset_allowin", 64'(wb_allowin), 64'd1);
    trace_ready = 1'b1;
    #1;
    chk("post_reset_zip_en", 64'(wb_rf_zip[ADDR_W+DATA_W]), 64'd0);
    repeat (3) tick();

    chk("scoreboard_retire_empty", 64'(exp_q.size()), 64'd0);
    chk("scoreboard_ex_empty", 64'(exq.size()), 64'd0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", s_checks + m_checks, s_errors + m_errors);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

Parametrised writeback stage that replaces the single-register WB stage with a DEPTH-entry in-order retire queue between MEM and the register file / debug trace port. Entries retire only when the trace sink is ready. Excepting instructions flush the younger queued work. The block also provides a two-port forwarding lookup, so ID can see writes that are queued but not yet retired.

## Interface
Parameters:
- DATA_W, 32, register write data width
- ADDR_W, 5, register address width
- PC_W, 32, PC width
- WE_W, 4, write-enable strobe width on trace/RF port
- DEPTH, 4, queue entries; power of two, ≥2

Ports (ENT_W = 1+WE_W+ADDR_W+DATA_W+PC_W; CNT_W = log2(DEPTH)+1):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- wb_allowin  out  1  queue can accept; equals ~full
- mem_to_wb_valid  in  1  MEM presents an entry
- mem_to_wb_wire  in  ENT_W  {ex, we[WE_W-1:0], waddr, wdata, pc}, MSB first
- wb_flush  in  1  external flush: drop all queued entries and the same-cycle push
- trace_ready  in  1  debug sink accepts the head this cycle
- debug_wb_pc  out  PC_W  head pc
- debug_wb_rf_we  out  WE_W  head we, gated by retire and ~ex
- debug_wb_rf_wnum  out  ADDR_W  head waddr
- debug_wb_rf_wdata  out  DATA_W  head wdata
- wb_rf_zip  out  1+ADDR_W+DATA_W  {|debug_wb_rf_we, waddr, wdata} to RF write port
- fwd_raddr  in  2*ADDR_W  two ID read addresses, port 0 in the low field
- fwd_hit  out  2  per-port queued-write match
- fwd_data  out  2*DATA_W  per-port forwarded data
- wb_ex  out  1  registered one-cycle exception pulse
- wb_ex_pc  out  PC_W  pc of the excepting entry; held until the next exception
- wb_count  out  CNT_W  occupied entries

## Operation
- Storage is a circular buffer. rd_ptr and wr_ptr are CNT_W bits wide, including a wrap bit.
  - empty: pointers are equal.
  - full: index bits are equal and the wrap bits differ.
- push = mem_to_wb_valid & wb_allowin & ~wb_flush & ~ex_retire.
- retire = ~empty & trace_ready.
- ex_retire = retire & head.ex.
- A normal retire (head.ex=0):
  - debug_wb_rf_we = head.we; the RF write occurs this cycle.
  - rd_ptr advances by 1.
- An exception retire (head.ex=1):
  - debug_wb_rf_we = 0; no RF write.
  - rd_ptr is set to wr_ptr, dropping all younger entries. A same-cycle push is dropped.
  - Next cycle: wb_ex=1 and wb_ex_pc=head.pc.
- wb_flush:
  - Next state is rd_ptr=wr_ptr, with any push suppressed.
  - A same-cycle retire still completes (RF write and trace happen); the flush only drops the remainder.
- Simultaneous push and normal retire: both pointers advance, count unchanged.
- Full: wb_allowin=0. There is no pass-through, even when retiring that cycle.
- Forwarding, per port:
  - Scan the valid entries from youngest to oldest. Take the first with waddr==fwd_raddr, we≠0, ex=0, and waddr≠0.
  - fwd_hit=1 and fwd_data=that entry's wdata; otherwise fwd_hit=0 and fwd_data=0.
  - The lookup is combinational on current contents and ignores the same-cycle push.
  - An entry still matches in its retire cycle; the RF takes over from the next cycle.
- Outputs when empty: debug_wb_rf_we=0 and the wb_rf_zip enable=0. PC/wnum/wdata are don't-care but must not be X after reset: storage is zero-initialised on reset.

## Timing
- Reset values:
  - wb_allowin=1, wb_count=0, wb_ex=0, wb_ex_pc=0.
  - All debug/zip enables 0, fwd_hit=0, fwd_data=0.
  - Pointers 0.
- Reset dominates flush, push and retire in the same cycle.
- Latency: an entry pushed in cycle N is at the head and retirable in cycle N+1 at the earliest.
- Retire outputs are combinational from the head and trace_ready. wb_rf_zip and the debug port are valid in the same cycle.
- wb_count, wb_allowin and fwd_* reflect the post-edge state, so a push or retire in cycle N is visible in cycle N+1.
- wb_ex is high for exactly one cycle, even on back-to-back exceptions (each gets its own pulse).

## Test plan
- Reset, then idle: wb_allowin=1, wb_count=0, wb_ex=0, all enables 0.
- Push 4 entries (waddr 1..4, wdata 0x11..0x44, we=0xF) with trace_ready=0 → wb_allowin=0 after the 4th and wb_count=4. Raise trace_ready → one retire per cycle in order, each with wb_rf_zip enable=1.
- Push waddr=5 with 0xA, then waddr=5 with 0xB, trace_ready=0; fwd_raddr port0=5 → fwd_hit[0]=1, fwd_data=0xB. fwd_raddr=0 → no hit, even with queued writes to r0.
- Queue {pc 0x1c000000 normal, pc 0x1c000004 ex=1, pc 0x1c000008 normal}, enable trace → first entry writes; the second produces no write; wb_ex=1 and wb_ex_pc=0x1c000004 next cycle; the third is never retired; wb_count=0.
- Full queue with a retire and a push in the same cycle → push refused (wb_allowin=0), count 4→3. wb_flush together with a retire → the head still writes, the rest are dropped, count=0 next cycle.
- Assert reset with 3 entries queued → next cycle wb_count=0, wb_allowin=1, no trace output.
